// File: rtl/usart_tx.sv
// 8N1 UART transmitter with a registered serial line and BPS_DIV clocks per bit.
// Define USART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module usart_tx #(
  parameter int BPS_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data_i,
  output logic       tx_data,
  output logic       tx_busy,
  output logic       tx_done
);

`ifdef USART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [12:0] DIV_LAST = 13'(BPS_DIV - 1);

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        line_q, line_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick;
`ifdef USART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  assign tick = (cnt_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
`ifdef USART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (tx_start) begin
          sh_d    = tx_data_i;
`ifdef USART_TX_PARITY_EN
          par_d   = ^tx_data_i;
`endif
          state_d = START;
        end
      end
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
`ifdef USART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end
      end
`ifdef USART_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + 13'd1;

    // Line value is derived from the next state so the registered output lines up with it.
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = sh_d[0];
`ifdef USART_TX_PARITY_EN
      PARITY:  line_d = par_q;
`endif
      default: line_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef USART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef USART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_data = line_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_usart_tx.sv
// Directed bench for usart_tx: default divider instance plus a BPS_DIV=2 instance.
module tb_usart_tx;
  localparam int DIV = 434;
`ifdef USART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] F55 = 11'b1_0_01010101_0;
  localparam logic [10:0] FA3 = 11'b1_0_10100011_0;
  localparam logic [10:0] F0F = 11'b1_0_00001111_0;
  localparam logic [10:0] F00 = 11'b1_0_00000000_0;
  localparam logic [10:0] F81 = 11'b1_0_10000001_0;
  localparam logic [10:0] FC6 = 11'b1_0_11000110_0;
`else
  localparam int NB = 10;
  localparam logic [10:0] F55 = 11'b0_1_01010101_0;
  localparam logic [10:0] FA3 = 11'b0_1_10100011_0;
  localparam logic [10:0] F0F = 11'b0_1_00001111_0;
  localparam logic [10:0] F00 = 11'b0_1_00000000_0;
  localparam logic [10:0] F81 = 11'b0_1_10000001_0;
  localparam logic [10:0] FC6 = 11'b0_1_11000110_0;
`endif

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start, tx_start2;
  logic [7:0] tx_data_i, tx_data_i2;
  logic       tx_data, tx_busy, tx_done;
  logic       tx_data2, tx_busy2, tx_done2;
  int         n_total = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  usart_tx dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data_i(tx_data_i),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  usart_tx #(.BPS_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .tx_start(tx_start2), .tx_data_i(tx_data_i2),
    .tx_data(tx_data2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Call at a negedge; returns at the negedge of the first START cycle.
  task automatic start_req(input logic [7:0] d);
    tx_start  = 1'b1;
    tx_data_i = d;
    @(negedge clk);
    tx_start  = 1'b0;
  endtask

  // Samples a whole frame starting at the first START cycle; returns at the tx_done negedge.
  task automatic rx_frame(input string name, input logic [7:0] data, input logic [10:0] exp,
                          input int inject_at);
    logic [10:0] got;
    logic [10:0] unstable;
    int busy_cnt, done_cnt;
    got = '0; unstable = '0; busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < NB * DIV; i++) begin
      if (i > 0) @(negedge clk);
      if (i == inject_at) begin
        tx_start  = 1'b1;
        tx_data_i = 8'hFF;
      end else begin
        tx_start = 1'b0;
      end
      if (i % DIV == 0) got[i / DIV] = tx_data;
      else if (tx_data !== got[i / DIV]) unstable[i / DIV] = 1'b1;
      if (tx_busy === 1'b1) busy_cnt++;
      if (tx_done !== 1'b0) done_cnt++;
    end
    for (int k = 0; k < NB; k++)
      check($sformatf("%s bit%0d", name, k), 32'(got[k]), 32'(exp[k]));
    check({name, " byte"}, 32'(got[8:1]), 32'(data));
    check({name, " bit_hold"}, 32'(unstable), 32'd0);
    check({name, " busy_cycles"}, busy_cnt, NB * DIV);
    check({name, " early_done"}, done_cnt, 0);
    @(negedge clk);
    tx_start = 1'b0;
    check({name, " done"}, 32'({tx_done, tx_busy, tx_data}), 32'b101);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[3];
    int   bad;
    logic [21:0] s2;
    int   busy2;
`ifdef USART_TX_PARITY_EN
    vecs[0] = '{8'h07, 11'b1_1_00000111_0};
    vecs[1] = '{8'h03, 11'b1_0_00000011_0};
    vecs[2] = '{8'hFE, 11'b1_1_11111110_0};
`else
    vecs[0] = '{8'h3C, 11'b0_1_00111100_0};
    vecs[1] = '{8'h01, 11'b0_1_00000001_0};
    vecs[2] = '{8'hFE, 11'b0_1_11111110_0};
`endif
    rst = 1'b1; tx_start = 1'b1; tx_data_i = 8'h55; tx_start2 = 1'b0; tx_data_i2 = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({tx_data, tx_busy, tx_done}), 32'b100);
    check("reset_state2", 32'({tx_data2, tx_busy2, tx_done2}), 32'b100);

    // First cycle out of reset with tx_start already high is the accept cycle.
    rst = 1'b0;
    @(negedge clk);
    tx_start = 1'b0;
    rx_frame("f55", 8'h55, F55, -1);
    @(negedge clk);
    check("done_pulse_width", 32'({tx_done, tx_data}), 32'b01);

    for (int v = 0; v < 3; v++) begin
      start_req(vecs[v].data);
      rx_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].frame, -1);
      @(negedge clk);
    end

    // Back-to-back: request issued in the tx_done cycle.
    start_req(8'hA3);
    rx_frame("fA3", 8'hA3, FA3, -1);
    tx_start = 1'b1; tx_data_i = 8'h0F;
    @(negedge clk);
    tx_start = 1'b0;
    rx_frame("f0F", 8'h0F, F0F, -1);

    // Request while busy must be dropped.
    @(negedge clk);
    start_req(8'h00);
    rx_frame("f00", 8'h00, F00, 1000);
    bad = 0;
    repeat (3 * DIV) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || tx_data !== 1'b1 || tx_done !== 1'b0) bad++;
    end
    check("no_queued_frame", bad, 0);

    // Reset during data bit 3.
    start_req(8'h55);
    repeat (4 * DIV + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_line", 32'({tx_data, tx_busy, tx_done}), 32'b100);
    bad = 0;
    repeat (NB * DIV) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx_data !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    check("abort_no_done", bad, 0);
    start_req(8'h81);
    rx_frame("f81", 8'h81, F81, -1);

    // Minimum divider on the second instance.
    @(negedge clk);
    tx_start2 = 1'b1; tx_data_i2 = 8'hC6;
    @(negedge clk);
    tx_start2 = 1'b0;
    s2 = '0; busy2 = 0;
    for (int i = 0; i < NB * 2; i++) begin
      if (i > 0) @(negedge clk);
      s2[i] = tx_data2;
      if (tx_busy2 === 1'b1) busy2++;
    end
    for (int k = 0; k < NB; k++)
      check($sformatf("div2 bit%0d", k), 32'(s2[2*k+1 -: 2]), {30'd0, FC6[k], FC6[k]});
    check("div2 busy_cycles", busy2, NB * 2);
    @(negedge clk);
    check("div2 done", 32'({tx_done2, tx_busy2, tx_data2}), 32'b101);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
